cv32e40p_rf_recovery_ctrl: RTL and testbench
============================================

CV32E40P_RF_RECOVERY_CTRL -- requirements
Module: cv32e40p_rf_recovery_ctrl

Interface
REQ-001 SHALL have parameter FPU, default 0: 1 = restore FP registers 32..63 as well as 0..31.
REQ-002 SHALL have parameter PULP_ZFINX, default 0: 1 = FP values live in GPRs, so only 0..31 are restored even when FPU=1.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port recover_req_i, input, 1: single-cycle request to start a restore.
REQ-006 SHALL have port halt_req_o, output, 1: request to the core controller to halt.
REQ-007 SHALL have port core_halted_i, input, 1: core is halted and its RF write ports are free.
REQ-008 SHALL have ports ckpt_raddr_a_o and ckpt_raddr_b_o, output, 6 each: checkpoint store read addresses.
REQ-009 SHALL have ports ckpt_rdata_a_i and ckpt_rdata_b_i, input, 32 each: checkpoint data, valid 1 cycle after the address.
REQ-010 SHALL have ports ckpt_par_a_i and ckpt_par_b_i, input, 1 each: even-parity bits, aligned with the rdata.
REQ-011 SHALL have port recover_o, output, 1: drives the core's recover_i.
REQ-012 SHALL have ports regfile_waddr_a_o (output, 6), regfile_wdata_a_o (output, 32) and regfile_we_a_o (output, 1): RF write port A.
REQ-013 SHALL have ports regfile_waddr_b_o (output, 6), regfile_wdata_b_o (output, 32) and regfile_we_b_o (output, 1): RF write port B.
REQ-014 SHALL have port recover_done_o, output, 1: one-cycle pulse on successful completion.
REQ-015 SHALL have port recover_err_o, output, 1: one-cycle pulse when a restore is aborted on a parity error.

Function
REQ-016 SHALL set NREGS = 64 when FPU=1 and PULP_ZFINX=0, otherwise 32; the number of register pairs NP = NREGS/2.
REQ-017 SHALL use FSM states IDLE, WAIT_HALT, COPY, DRAIN and DONE.
REQ-018 SHALL transition IDLE->WAIT_HALT when recover_req_i=1; recover_req_i in any other state SHALL be ignored.
REQ-019 SHALL assert halt_req_o in WAIT_HALT, COPY and DRAIN; SHALL transition WAIT_HALT->COPY when core_halted_i=1 and clear the pair counter cnt to 0.
REQ-020 SHALL, in each COPY cycle, drive ckpt_raddr_a_o=2*cnt and ckpt_raddr_b_o=2*cnt+1, then increment cnt; SHALL transition COPY->DRAIN after the cycle with cnt=NP-1.
REQ-021 SHALL write each pair 1 cycle after its read: register the read addresses, drive waddr_a/b from the registered values and wdata_a/b directly from ckpt_rdata_a/b_i; we_a/b SHALL be 1 in the COPY cycles after the first, and in DRAIN.
REQ-022 SHALL hold regfile_we_a_o=0 for address 0 (x0 is never written).
REQ-023 SHALL assert recover_o exactly in the cycles where any we output may be 1 (COPY after its first cycle, and DRAIN).
REQ-024 SHALL transition DRAIN->DONE and DONE->IDLE unconditionally; recover_done_o=1 only in DONE.
REQ-025 SHALL make the latency from the core_halted_i sampling edge to recover_done_o equal to NP+2 cycles (18 for NREGS=32).
REQ-026 SHALL ignore core_halted_i deasserting during COPY or DRAIN; the sequence continues.
REQ-027 SHALL drive ckpt_raddr outputs, waddr outputs and wdata outputs to 0 outside COPY and DRAIN.

Reset
REQ-028 SHALL, on rst_i (including mid-sequence), immediately enter IDLE, clear cnt, and force every output to 0; no partial write SHALL be completed.

Configuration
REQ-029 SHALL implement parity checking under macro CV32E40P_RF_RECOVERY_PARITY_EN: with it defined, a write cycle where ^{rdata,par} != 0 on either port SHALL force both we outputs to 0 in that cycle, pulse recover_err_o, and enter IDLE (no DONE); without it, the parity inputs are ignored and recover_err_o is tied to 0.

Verification
REQ-030 SHALL cover: FPU=0, recover_req_i pulse, core_halted_i=1 two cycles later -> 16 write cycles covering addresses 0..31, we_a=0 at addr 0, recover_done_o 18 cycles after the halt edge.
REQ-031 SHALL cover: FPU=1, PULP_ZFINX=0 -> 32 write cycles, last pair 62/63, recover_done_o at +34; FPU=1, PULP_ZFINX=1 -> 16 write cycles.
REQ-032 SHALL cover: recover_req_i pulsed during COPY -> no effect; exactly one recover_done_o pulse.
REQ-033 SHALL cover: rst_i=1 at the 5th COPY cycle -> same-cycle all outputs 0; the next request restarts from pair 0.
REQ-034 SHALL cover: macro defined, bad parity on port B for pair 7 -> we_a=we_b=0 in that cycle, recover_err_o=1, state IDLE, no recover_done_o; macro undefined -> full restore completes.
REQ-035 SHALL cover: core_halted_i held 0 for 100 cycles -> halt_req_o stays 1, recover_o stays 0, no writes.

Source files
------------

// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file restore sequencer: halts the core, then copies the checkpoint store into the RF two registers per cycle.
// Optional parity abort is enabled by defining CV32E40P_RF_RECOVERY_PARITY_EN.
module cv32e40p_rf_recovery_ctrl #(
  parameter int FPU        = 0,
  parameter int PULP_ZFINX = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        recover_req_i,
  output logic        halt_req_o,
  input  logic        core_halted_i,
  output logic [5:0]  ckpt_raddr_a_o,
  output logic [5:0]  ckpt_raddr_b_o,
  input  logic [31:0] ckpt_rdata_a_i,
  input  logic [31:0] ckpt_rdata_b_i,
  input  logic        ckpt_par_a_i,
  input  logic        ckpt_par_b_i,
  output logic        recover_o,
  output logic [5:0]  regfile_waddr_a_o,
  output logic [31:0] regfile_wdata_a_o,
  output logic        regfile_we_a_o,
  output logic [5:0]  regfile_waddr_b_o,
  output logic [31:0] regfile_wdata_b_o,
  output logic        regfile_we_b_o,
  output logic        recover_done_o,
  output logic        recover_err_o
);
  localparam int NREGS = (FPU == 1 && PULP_ZFINX == 0) ? 64 : 32;
  localparam int NP    = NREGS / 2;

  typedef enum logic [2:0] {IDLE, WAIT_HALT, COPY, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [5:0]  waddr_a_q, waddr_b_q;
  logic        last, wr_cyc, par_err;

  assign last   = (cnt == 5'(NP - 1));
  // Write cycle trails its read by one: every COPY cycle but the first, plus DRAIN
  assign wr_cyc = (state == COPY && cnt != 5'd0) || (state == DRAIN);

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
  assign par_err = wr_cyc && ((^{ckpt_rdata_a_i, ckpt_par_a_i}) || (^{ckpt_rdata_b_i, ckpt_par_b_i}));
`else
  logic unused_par;
  assign unused_par = ckpt_par_a_i ^ ckpt_par_b_i;
  assign par_err    = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      waddr_a_q <= '0;
      waddr_b_q <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state == COPY) ? cnt + 5'd1 : 5'd0;
      waddr_a_q <= (state == COPY) ? {cnt, 1'b0} : 6'd0;
      waddr_b_q <= (state == COPY) ? {cnt, 1'b1} : 6'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (recover_req_i) state_nxt = WAIT_HALT;
      WAIT_HALT: if (core_halted_i) state_nxt = COPY;
      COPY:      if (par_err) state_nxt = IDLE;
                 else if (last) state_nxt = DRAIN;
      DRAIN:     state_nxt = par_err ? IDLE : DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    halt_req_o        = 1'b0;
    ckpt_raddr_a_o    = '0;
    ckpt_raddr_b_o    = '0;
    recover_o         = 1'b0;
    regfile_waddr_a_o = '0;
    regfile_wdata_a_o = '0;
    regfile_we_a_o    = 1'b0;
    regfile_waddr_b_o = '0;
    regfile_wdata_b_o = '0;
    regfile_we_b_o    = 1'b0;
    recover_done_o    = 1'b0;
    recover_err_o     = 1'b0;
    case (state)
      WAIT_HALT: halt_req_o = 1'b1;
      COPY: begin
        halt_req_o     = 1'b1;
        ckpt_raddr_a_o = {cnt, 1'b0};
        ckpt_raddr_b_o = {cnt, 1'b1};
      end
      DRAIN:   halt_req_o     = 1'b1;
      DONE:    recover_done_o = 1'b1;
      default: ;
    endcase
    if (wr_cyc) begin
      recover_o         = 1'b1;
      regfile_waddr_a_o = waddr_a_q;
      regfile_wdata_a_o = ckpt_rdata_a_i;
      regfile_waddr_b_o = waddr_b_q;
      regfile_wdata_b_o = ckpt_rdata_b_i;
      // x0 is hardwired; never write it
      regfile_we_a_o    = !par_err && (waddr_a_q != 6'd0);
      regfile_we_b_o    = !par_err;
      recover_err_o     = par_err;
    end
  end
endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Directed bench: three configurations (FPU=0, FPU=1, FPU=1+ZFINX) share stimulus and a checkpoint-store model.
module tb_cv32e40p_rf_recovery_ctrl;
  logic clk = 1'b0;
  logic rst, req, halted;
  logic [31:0] rdata_a, rdata_b;
  logic par_a, par_b;
  int bad_pair;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic        halt[3], recover[3], we_a[3], we_b[3], done[3], err[3];
  logic [5:0]  raddr_a[3], raddr_b[3], waddr_a[3], waddr_b[3];
  logic [31:0] wdata_a[3], wdata_b[3];
  logic [93:0] obs[3];

  localparam int NP_T[3] = '{16, 32, 16};
  localparam logic [93:0] HALT_ONLY = {1'b1, 93'd0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cv32e40p_rf_recovery_ctrl #(
      .FPU(g == 0 ? 0 : 1),
      .PULP_ZFINX(g == 2 ? 1 : 0)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .recover_req_i(req), .halt_req_o(halt[g]),
      .core_halted_i(halted), .ckpt_raddr_a_o(raddr_a[g]), .ckpt_raddr_b_o(raddr_b[g]),
      .ckpt_rdata_a_i(rdata_a), .ckpt_rdata_b_i(rdata_b),
      .ckpt_par_a_i(par_a), .ckpt_par_b_i(par_b), .recover_o(recover[g]),
      .regfile_waddr_a_o(waddr_a[g]), .regfile_wdata_a_o(wdata_a[g]), .regfile_we_a_o(we_a[g]),
      .regfile_waddr_b_o(waddr_b[g]), .regfile_wdata_b_o(wdata_b[g]), .regfile_we_b_o(we_b[g]),
      .recover_done_o(done[g]), .recover_err_o(err[g])
    );
    assign obs[g] = {halt[g], raddr_a[g], raddr_b[g], recover[g], waddr_a[g], wdata_a[g], we_a[g],
                     waddr_b[g], wdata_b[g], we_b[g], done[g], err[g]};
  end

  function automatic logic [31:0] ck(input logic [5:0] a);
    return 32'hC0DE_0000 | (32'(a) * 32'h101);
  endfunction

  // Checkpoint store: one-cycle read latency, even parity, optional corruption on port B of one pair
  always @(posedge clk) begin
    rdata_a <= ck(raddr_a[1]);
    rdata_b <= ck(raddr_b[1]);
    par_a   <= ^ck(raddr_a[1]);
    par_b   <= (^ck(raddr_b[1])) ^ (bad_pair >= 0 && raddr_b[1] == 6'(2 * bad_pair + 1));
  end

  // k = cycles after the edge that sampled core_halted_i; done visible in cycle NP+1, captured on edge NP+2
  function automatic logic [93:0] exp_vec(input int np, input int k, input int err_k);
    logic h, rc, wa, wb, dn, er, wr;
    logic [5:0] ra, rb, xa, xb;
    logic [31:0] da, db;
    if (err_k >= 0 && k > err_k) return '0;
    wr = (k >= 1 && k <= np);
    h  = (k <= np);
    ra = (k < np) ? 6'(2 * k) : 6'd0;
    rb = (k < np) ? 6'(2 * k + 1) : 6'd0;
    rc = wr;
    xa = wr ? 6'(2 * (k - 1)) : 6'd0;
    xb = wr ? 6'(2 * k - 1) : 6'd0;
    da = wr ? ck(xa) : 32'd0;
    db = wr ? ck(xb) : 32'd0;
    wa = wr && (xa != 6'd0) && (k != err_k);
    wb = wr && (k != err_k);
    dn = (k == np + 1);
    er = (k == err_k);
    return {h, ra, rb, rc, xa, da, wa, xb, db, wb, dn, er};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input int idx, input logic [93:0] o, input logic [93:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, idx, o, e);
    end
  endtask

  task automatic chk_const(input string tag, input logic [93:0] e);
    for (int i = 0; i < 3; i++) chk(tag, i, obs[i], e);
  endtask

  task automatic run(input int hd, input int bp, input int rst_at, input string tag);
    int err_k;
    err_k = -1;
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    if (bp >= 0) err_k = bp + 1;
`endif
    bad_pair = bp;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (hd) begin
      chk_const({tag, "_wait"}, HALT_ONLY);
      tick();
    end
    chk_const({tag, "_wait"}, HALT_ONLY);
    halted = 1'b1;
    tick();
    for (int k = 0; k <= 36; k++) begin
      for (int i = 0; i < 3; i++) chk($sformatf("%s_k%0d", tag, k), i, obs[i], exp_vec(NP_T[i], k, err_k));
      if (k == 3) req = 1'b1;
      if (k == 4) req = 1'b0;
      if (k == 5) halted = 1'b0;
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk_const({tag, "_midrst"}, '0);
        tick();
        rst = 1'b0;
        break;
      end
      tick();
    end
    halted   = 1'b0;
    bad_pair = -1;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; halted = 1'b0; bad_pair = -1;
    tick();
    chk_const("reset", '0);
    rst = 1'b0;
    tick();
    chk_const("idle", '0);
    run(1, -1, -1, "basic");
    run(2, -1, 4, "rst");
    run(1, -1, -1, "restart");
    run(1, 7, -1, "parity");
    run(100, -1, -1, "longwait");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
